ped_signal_ctrl: RTL and testbench

- Downstream consumer of the one-hot traffic `light` code; drives the pedestrian crossing lamps (WALK / DON'T WALK) for the same junction.
- Latches pedestrian button requests and grants WALK only while the vehicle light is RED.
- Times a fixed WALK interval followed by a flashing DON'T WALK clearance interval.
- Any illegal (non-one-hot) light code is treated as a fault: the block locks into a safe, sticky state.

---
 rtl/ped_signal_ctrl.sv | 145 ++++++++++++++
 tb/tb_ped_signal_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK / DON'T WALK controller slaved to the
// one-hot vehicle light code. Requests are latched in IDLE and served only
// on RED; WALK is timed, then a flashing DON'T WALK clearance follows.
// Any non-one-hot light code locks the block into FAULT until reset.
// Optional feature macro: PED_CHIRP_EN (adds the chirp audio-cue output).
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       light,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             ped_wait,
    output logic [CNT_W-1:0] countdown,
`ifdef PED_CHIRP_EN
    output logic             chirp,
`endif
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

    state_t           state, state_nx;
    logic             req_q, req_nx;
    logic             toggle, toggle_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic light_ok, is_red, req_eff;

    assign light_ok = (light == RED) || (light == YELLOW) || (light == GREEN);
    assign is_red   = (light == RED);
    // A press in the same cycle RED is seen is enough to be granted.
    assign req_eff  = req_q | ped_btn;

    // State register: synchronous active-high reset to the safe IDLE view.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            toggle <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            req_q  <= req_nx;
            toggle <= toggle_nx;
            cnt    <= cnt_nx;
        end
    end

    // Next-state logic; an illegal light code overrides every other transition.
    always_comb begin
        state_nx  = state;
        req_nx    = req_q;
        toggle_nx = toggle;
        cnt_nx    = cnt;
        if (!light_ok) begin
            state_nx = FAULT;
            req_nx   = 1'b0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ped_btn) req_nx = 1'b1;
                    if (is_red && req_eff) begin
                        state_nx = WALK;
                        cnt_nx   = WALK_LOAD;
                        req_nx   = 1'b0;
                    end
                end
                WALK: begin
                    if (!is_red) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == '0) begin
                        state_nx  = FLASH;
                        cnt_nx    = FLASH_LOAD;
                        toggle_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                FLASH: begin
                    toggle_nx = ~toggle;
                    if (!is_red || cnt == '0) begin
                        state_nx  = IDLE;
                        cnt_nx    = '0;
                        toggle_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                default: begin
                    // FAULT is sticky; only reset leaves it.
                    state_nx = FAULT;
                    req_nx   = 1'b0;
                end
            endcase
        end
    end

    // Lamp decode from registered state only, so responses lag inputs by one edge.
    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        countdown = '0;
        fault     = 1'b0;
        case (state)
            WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
                countdown = cnt;
            end
            FLASH: begin
                dont_walk = toggle;
                countdown = cnt;
            end
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    assign ped_wait = req_q;

`ifdef PED_CHIRP_EN
    // Audio cue pulses on even countdown values while WALK is lit.
    assign chirp = (state == WALK) && !cnt[0];
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl with WALK_CYCLES=4, FLASH_CYCLES=4.
module tb_ped_signal_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       light;
    logic             ped_btn;
    logic             walk, dont_walk, ped_wait, fault;
    logic [CNT_W-1:0] countdown;
`ifdef PED_CHIRP_EN
    logic             chirp;
`endif

    int total = 0;
    int bad   = 0;

    ped_signal_ctrl #(
        .WALK_CYCLES (4),
        .FLASH_CYCLES(4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .light    (light),
        .ped_btn  (ped_btn),
        .walk     (walk),
        .dont_walk(dont_walk),
        .ped_wait (ped_wait),
        .countdown(countdown),
`ifdef PED_CHIRP_EN
        .chirp    (chirp),
`endif
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the full lamp view at once.
    task automatic chk_all(input string tag, input logic w, input logic dw,
                           input logic pw, input logic [CNT_W-1:0] cd, input logic f);
        chk({tag, ".walk"},      32'(walk),      32'(w));
        chk({tag, ".dont_walk"}, 32'(dont_walk), 32'(dw));
        chk({tag, ".ped_wait"},  32'(ped_wait),  32'(pw));
        chk({tag, ".countdown"}, 32'(countdown), 32'(cd));
        chk({tag, ".fault"},     32'(fault),     32'(f));
    endtask

    initial begin
        logic [3:0] exp_cd [4];
        logic       exp_dw [4];
        logic [2:0] seq    [3];
        exp_cd = '{4'd3, 4'd2, 4'd1, 4'd0};
        exp_dw = '{1'b1, 1'b0, 1'b1, 1'b0};
        seq    = '{3'b100, 3'b010, 3'b001};

        // 1: reset for two cycles
        reset = 1'b1; light = 3'b001; ped_btn = 1'b0;
        tick(); tick();
        chk_all("reset", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("idle_green", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // 2: latched press on green, then full WALK/FLASH on red
        ped_btn = 1'b1; tick(); ped_btn = 1'b0;
        chk_all("latch", 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        tick();
        chk_all("latch_hold", 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        light = 3'b100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("walk%0d", i), 1'b1, 1'b0, 1'b0, exp_cd[i], 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("flash%0d", i), 1'b0, exp_dw[i], 1'b0, exp_cd[i], 1'b0);
        end
        tick();
        chk_all("post_flash", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // 6: same-cycle press on red, extra press during WALK is discarded
        ped_btn = 1'b1; tick(); ped_btn = 1'b0;
        chk_all("grant_same", 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        ped_btn = 1'b1; tick(); ped_btn = 1'b0;
        chk_all("press_in_walk", 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk_all("flash_last", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("no_regrant%0d", i), 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        end

        // 3: abort WALK at countdown=2 with yellow
        ped_btn = 1'b1; tick(); ped_btn = 1'b0;
        chk_all("walk_b0", 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        tick();
        chk_all("walk_b1", 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
        light = 3'b010; tick();
        chk_all("abort", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        light = 3'b100; tick();
        chk_all("abort_no_regrant", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // 5: cycling legal lights without a request never grants WALK
        for (int i = 0; i < 30; i++) begin
            light = seq[i % 3];
            tick();
            chk("cycle_walk", 32'(walk), 32'd0);
            chk("cycle_wait", 32'(ped_wait), 32'd0);
        end

        // Reset mid-interval returns to the reset view on the next edge
        light = 3'b100; ped_btn = 1'b1; tick(); ped_btn = 1'b0;
        chk_all("walk_c", 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_all("reset_mid", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // 4: illegal code is sticky, ignores buttons until reset
        light = 3'b001; ped_btn = 1'b1; tick();
        chk_all("pre_fault", 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        ped_btn = 1'b0; light = 3'b110; tick();
        chk_all("fault", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        light = 3'b100; ped_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("fault_hold%0d", i), 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        end
        ped_btn = 1'b0; light = 3'b000; tick();
        chk_all("fault_zero", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        reset = 1'b1; light = 3'b001; tick(); reset = 1'b0;
        chk_all("fault_cleared", 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
